mmio_decoder: RTL and testbench
===============================

# mmio_decoder

Combinational address decoder between the CPU data-memory port and two slaves: main RAM and the DMA controller's MMIO register window. Each CPU request is steered to exactly one slave by address. The selected slave's read data and ready are returned to the CPU with zero added latency. The block has no internal state; reset only gates the outputs.

## Interface
Parameters:
- ADDR_W, 32: address width.
- XLEN, 32: data width.
- DMA_ADDR_MASK, 32'hFFFF_FFE0: bits compared for a DMA hit; defines a 32-byte window.
- DMA_ADDR_MATCH, 32'h4000_0000: DMA window base, which is also DMA_BASE_ADDR. It must be 32-byte aligned.

Ports:
- clk  in  1  system clock; no registers are clocked by it.
- rst  in  1  reset, asynchronous, active-high.
- cpu_mem_req  in  1  CPU access request.
- cpu_mem_we  in  1  CPU write enable (1 = write).
- cpu_mem_addr  in  ADDR_W  CPU byte address.
- cpu_mem_wdata  in  XLEN  CPU write data.
- cpu_mem_rdata  out  XLEN  read data from the selected slave.
- cpu_mem_ready  out  1  access completes this cycle.
- ram_mem_req  out  1  RAM request.
- ram_mem_we  out  1  RAM write enable.
- ram_mem_addr  out  ADDR_W  RAM address.
- ram_mem_wdata  out  XLEN  RAM write data.
- ram_mem_rdata  in  XLEN  RAM read data.
- ram_mem_ready  in  1  RAM ready.
- dma_mmio_req  out  1  DMA MMIO request.
- dma_mmio_we  out  1  DMA MMIO write enable.
- dma_mmio_addr  out  ADDR_W  DMA MMIO address.
- dma_mmio_wdata  out  XLEN  DMA MMIO write data.
- dma_mmio_rdata  in  XLEN  DMA MMIO read data.
- dma_mmio_ready  in  1  DMA MMIO ready.

## Operation
- Hit signal: hit = ((cpu_mem_addr & DMA_ADDR_MASK) == DMA_ADDR_MATCH). The full address is compared; there is no aliasing.
- With the defaults, addresses 0x4000_0000–0x4000_001F hit. 0x4000_0020 and above, and everything below the base, go to RAM.
- Request steering:
  - dma_mmio_req = cpu_mem_req & hit & ~rst.
  - ram_mem_req = cpu_mem_req & ~hit & ~rst.
  - The two requests are never high at the same time.
  - With cpu_mem_req = 0, both are 0.
- Pass-through: cpu_mem_we, cpu_mem_addr and cpu_mem_wdata drive the we/addr/wdata outputs of both slaves unmodified, at all times. Only the req lines select the slave. The address is not rebased; each slave decodes its own offset.
- Return path:
  - cpu_mem_ready = dma_mmio_req ? dma_mmio_ready : (ram_mem_req ? ram_mem_ready : 0).
  - cpu_mem_rdata = dma_mmio_req ? dma_mmio_rdata : (ram_mem_req ? ram_mem_rdata : 0).
  - Read data is therefore 0 when there is no request.
- Access size: whole words only; no byte enables. Address bits [1:0] are forwarded and take no part in decode beyond the mask.

## Timing
- Purely combinational from cpu_* and slave inputs to all outputs. Decode and return add zero cycles.
- Handshake: the CPU holds req, we, addr and wdata until it sees cpu_mem_ready at a rising clk edge. A slave with multi-cycle latency holds its ready low; the decoder keeps the same selection while the address is stable.
- The CPU must not change the address while waiting for ready. If it does, the selection follows the new address immediately; no transaction is tracked.
- Reset:
  - While rst = 1: ram_mem_req = dma_mmio_req = cpu_mem_ready = 0 and cpu_mem_rdata = 0. This takes effect immediately, with no clock needed.
  - Pass-through we/addr/wdata remain live.
  - Deasserting rst mid-request: the request is presented to the slave in the same delta; no cycle is lost.
- Simultaneous events: there is no arbitration. There is a single master, and only one slave is ever selected.

## Test plan
- Idle: rst deasserted, cpu_mem_req = 0 → ram_mem_req = 0, dma_mmio_req = 0, cpu_mem_ready = 0, cpu_mem_rdata = 0.
- RAM round trip: the bench uses a zero-wait RAM model with ready = req.
  - Write 0x1234_5678 to 0x0000_0010 → ram_mem_req = 1, ram_mem_we = 1, dma_mmio_req = 0, cpu_mem_ready = 1.
  - Read 0x0000_0010 → cpu_mem_rdata = 0x1234_5678.
- DMA read: the bench uses a DMA model returning 0xD00D_0000 | addr[5:2].
  - Read 0x4000_0000 → dma_mmio_req = 1, ram_mem_req = 0, dma_mmio_we = 0, cpu_mem_rdata = 0xD00D_0000.
- Window boundary:
  - Read 0x4000_001C → DMA selected, rdata 0xD00D_0007.
  - Read 0x4000_0020 → RAM selected.
  - Read 0x3FFF_FFFC → RAM selected.
- Reset gating: hold rst = 1 with cpu_mem_req = 1 at 0x4000_0000 → both slave reqs and cpu_mem_ready = 0. Release rst → dma_mmio_req = 1 immediately.
- Random: 200 cycles of random req, we, addr and wdata.
  - Exactly one slave req equals cpu_mem_req, matching the hit formula.
  - The selected slave's we equals cpu_mem_we.
  - cpu_mem_ready equals cpu_mem_req.
  - No slave activity when req = 0.

Source files
------------

// File: rtl/mmio_decoder.sv
// mmio_decoder: steers each CPU data-memory request to main RAM or the DMA
// controller's MMIO window by address, and muxes the selected slave's
// ready/rdata back to the CPU. Purely combinational; rst only gates outputs.
module mmio_decoder #(
  parameter int unsigned           ADDR_W         = 32,
  parameter int unsigned           XLEN           = 32,
  parameter logic [ADDR_W-1:0]     DMA_ADDR_MASK  = 32'hFFFF_FFE0,
  parameter logic [ADDR_W-1:0]     DMA_ADDR_MATCH = 32'h4000_0000
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_mem_req,
  input  logic              cpu_mem_we,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [XLEN-1:0]   cpu_mem_wdata,
  output logic [XLEN-1:0]   cpu_mem_rdata,
  output logic              cpu_mem_ready,

  output logic              ram_mem_req,
  output logic              ram_mem_we,
  output logic [ADDR_W-1:0] ram_mem_addr,
  output logic [XLEN-1:0]   ram_mem_wdata,
  input  logic [XLEN-1:0]   ram_mem_rdata,
  input  logic              ram_mem_ready,

  output logic              dma_mmio_req,
  output logic              dma_mmio_we,
  output logic [ADDR_W-1:0] dma_mmio_addr,
  output logic [XLEN-1:0]   dma_mmio_wdata,
  input  logic [XLEN-1:0]   dma_mmio_rdata,
  input  logic              dma_mmio_ready
);

  // The clock is part of the bus contract but nothing here is registered.
  logic unused_clk;
  assign unused_clk = clk;

  // Slave selected for the current request.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_DMA  = 2'd2
  } sel_e;

  logic dma_hit;
  sel_e sel;

  // Full-address compare against the DMA window; no aliasing.
  assign dma_hit = ((cpu_mem_addr & DMA_ADDR_MASK) == DMA_ADDR_MATCH);

  // Pick at most one slave; reset forces no selection without a clock.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sel = SEL_NONE;
    if (!rst && cpu_mem_req) begin
      sel = dma_hit ? SEL_DMA : SEL_RAM;
    end
  end

  // Request lines are the only thing that distinguishes the two slaves.
  assign ram_mem_req  = (sel == SEL_RAM);
  assign dma_mmio_req = (sel == SEL_DMA);

  // Write enable, address and data go to both slaves unmodified, even in
  // reset; each slave decodes its own offset from the full address.
  assign ram_mem_we     = cpu_mem_we;
  assign ram_mem_addr   = cpu_mem_addr;
  assign ram_mem_wdata  = cpu_mem_wdata;
  assign dma_mmio_we    = cpu_mem_we;
  assign dma_mmio_addr  = cpu_mem_addr;
  assign dma_mmio_wdata = cpu_mem_wdata;

  // Return path: selected slave's ready/rdata, zero when nothing selected.
  always_comb begin
    cpu_mem_ready = 1'b0;
    cpu_mem_rdata = '0;
    unique case (sel)
      SEL_RAM: begin
        cpu_mem_ready = ram_mem_ready;
        cpu_mem_rdata = ram_mem_rdata;
      end
      SEL_DMA: begin
        cpu_mem_ready = dma_mmio_ready;
        cpu_mem_rdata = dma_mmio_rdata;
      end
      default: begin
        cpu_mem_ready = 1'b0;
        cpu_mem_rdata = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_decoder.sv
// Self-checking bench for mmio_decoder: directed steps then random traffic,
// against a window-range reference model and simple RAM/DMA slave models.
module tb_mmio_decoder;

  localparam logic [31:0] DMA_BASE = 32'h4000_0000;
  localparam int unsigned DMA_SIZE = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_mem_req;
  logic        cpu_mem_we;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_wdata;
  logic [31:0] cpu_mem_rdata;
  logic        cpu_mem_ready;
  logic        ram_mem_req;
  logic        ram_mem_we;
  logic [31:0] ram_mem_addr;
  logic [31:0] ram_mem_wdata;
  logic [31:0] ram_mem_rdata;
  logic        ram_mem_ready;
  logic        dma_mmio_req;
  logic        dma_mmio_we;
  logic [31:0] dma_mmio_addr;
  logic [31:0] dma_mmio_wdata;
  logic [31:0] dma_mmio_rdata;
  logic        dma_mmio_ready;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mmio_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_mem_req    (cpu_mem_req),
    .cpu_mem_we     (cpu_mem_we),
    .cpu_mem_addr   (cpu_mem_addr),
    .cpu_mem_wdata  (cpu_mem_wdata),
    .cpu_mem_rdata  (cpu_mem_rdata),
    .cpu_mem_ready  (cpu_mem_ready),
    .ram_mem_req    (ram_mem_req),
    .ram_mem_we     (ram_mem_we),
    .ram_mem_addr   (ram_mem_addr),
    .ram_mem_wdata  (ram_mem_wdata),
    .ram_mem_rdata  (ram_mem_rdata),
    .ram_mem_ready  (ram_mem_ready),
    .dma_mmio_req   (dma_mmio_req),
    .dma_mmio_we    (dma_mmio_we),
    .dma_mmio_addr  (dma_mmio_addr),
    .dma_mmio_wdata (dma_mmio_wdata),
    .dma_mmio_rdata (dma_mmio_rdata),
    .dma_mmio_ready (dma_mmio_ready)
  );

  // Zero-wait RAM slave: 256-word store indexed by word address.
  logic [31:0] ram_store [256];
  assign ram_mem_ready = ram_mem_req;
  assign ram_mem_rdata = ram_store[ram_mem_addr[9:2]];

  // RAM write on the clock edge that completes a write request.
  always @(posedge clk) begin
    if (ram_mem_req && ram_mem_we) ram_store[ram_mem_addr[9:2]] <= ram_mem_wdata;
  end

  // DMA slave: zero-wait, read data tags the word index.
  assign dma_mmio_ready = dma_mmio_req;
  assign dma_mmio_rdata = 32'hD00D_0000 | {28'd0, dma_mmio_addr[5:2]};

  // Reference: an address is a DMA hit iff it lies in [BASE, BASE+SIZE).
  function automatic bit ref_hit(input logic [31:0] a);
    return (a >= DMA_BASE) && (a < DMA_BASE + DMA_SIZE);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a CPU request on the falling edge; outputs settle before sampling.
  task automatic drive(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_mem_req   = req;
    cpu_mem_we    = we;
    cpu_mem_addr  = a;
    cpu_mem_wdata = d;
    #2;
  endtask

  initial begin
    logic        r_req, r_we, hit;
    logic [31:0] r_addr, r_data, exp_rdata;
    int          kind;

    for (int i = 0; i < 256; i++) ram_store[i] = 32'd0;
    rst = 1'b1;
    cpu_mem_req = 1'b0;
    cpu_mem_we = 1'b0;
    cpu_mem_addr = 32'd0;
    cpu_mem_wdata = 32'd0;
    #1;
    check("rst_ram_req", {31'd0, ram_mem_req}, 32'd0);
    check("rst_dma_req", {31'd0, dma_mmio_req}, 32'd0);
    check("rst_ready", {31'd0, cpu_mem_ready}, 32'd0);
    repeat (2) @(posedge clk);
    rst = 1'b0;

    // Idle
    drive(1'b0, 1'b0, 32'h0000_0010, 32'd0);
    check("idle_ram_req", {31'd0, ram_mem_req}, 32'd0);
    check("idle_dma_req", {31'd0, dma_mmio_req}, 32'd0);
    check("idle_ready", {31'd0, cpu_mem_ready}, 32'd0);
    check("idle_rdata", cpu_mem_rdata, 32'd0);

    // RAM write then read back
    drive(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678);
    check("ramw_req", {31'd0, ram_mem_req}, 32'd1);
    check("ramw_we", {31'd0, ram_mem_we}, 32'd1);
    check("ramw_dma_req", {31'd0, dma_mmio_req}, 32'd0);
    check("ramw_ready", {31'd0, cpu_mem_ready}, 32'd1);
    check("ramw_wdata", ram_mem_wdata, 32'h1234_5678);
    drive(1'b1, 1'b0, 32'h0000_0010, 32'd0);
    check("ramr_rdata", cpu_mem_rdata, 32'h1234_5678);

    // DMA read at base
    drive(1'b1, 1'b0, 32'h4000_0000, 32'd0);
    check("dma0_req", {31'd0, dma_mmio_req}, 32'd1);
    check("dma0_ram_req", {31'd0, ram_mem_req}, 32'd0);
    check("dma0_we", {31'd0, dma_mmio_we}, 32'd0);
    check("dma0_rdata", cpu_mem_rdata, 32'hD00D_0000);

    // Window boundaries
    drive(1'b1, 1'b0, 32'h4000_001C, 32'd0);
    check("top_dma_req", {31'd0, dma_mmio_req}, 32'd1);
    check("top_rdata", cpu_mem_rdata, 32'hD00D_0007);
    drive(1'b1, 1'b0, 32'h4000_0020, 32'd0);
    check("above_ram_req", {31'd0, ram_mem_req}, 32'd1);
    check("above_dma_req", {31'd0, dma_mmio_req}, 32'd0);
    drive(1'b1, 1'b0, 32'h3FFF_FFFC, 32'd0);
    check("below_ram_req", {31'd0, ram_mem_req}, 32'd1);
    check("below_dma_req", {31'd0, dma_mmio_req}, 32'd0);

    // Reset gating with a pending DMA request, then immediate release
    @(negedge clk);
    rst = 1'b1;
    cpu_mem_req = 1'b1;
    cpu_mem_we = 1'b1;
    cpu_mem_addr = 32'h4000_0004;
    cpu_mem_wdata = 32'hCAFE_F00D;
    #1;
    check("rstg_dma_req", {31'd0, dma_mmio_req}, 32'd0);
    check("rstg_ram_req", {31'd0, ram_mem_req}, 32'd0);
    check("rstg_ready", {31'd0, cpu_mem_ready}, 32'd0);
    check("rstg_rdata", cpu_mem_rdata, 32'd0);
    check("rstg_addr_live", dma_mmio_addr, 32'h4000_0004);
    check("rstg_wdata_live", ram_mem_wdata, 32'hCAFE_F00D);
    rst = 1'b0;
    #1;
    check("rel_dma_req", {31'd0, dma_mmio_req}, 32'd1);
    check("rel_ready", {31'd0, cpu_mem_ready}, 32'd1);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      r_req  = 1'($urandom_range(0, 1));
      r_we   = 1'($urandom_range(0, 1));
      r_data = $urandom;
      kind   = $urandom_range(0, 3);
      case (kind)
        0:       r_addr = DMA_BASE + 32'($urandom_range(0, DMA_SIZE - 1));
        1:       r_addr = DMA_BASE - 32'd64 + 32'($urandom_range(0, 127));
        2:       r_addr = {22'd0, 10'($urandom)};
        default: r_addr = $urandom;
      endcase
      drive(r_req, r_we, r_addr, r_data);
      hit = ref_hit(r_addr);
      check("rnd_dma_req", {31'd0, dma_mmio_req}, {31'd0, r_req & hit});
      check("rnd_ram_req", {31'd0, ram_mem_req}, {31'd0, r_req & ~hit});
      check("rnd_ready", {31'd0, cpu_mem_ready}, {31'd0, r_req});
      check("rnd_we", {31'd0, hit ? dma_mmio_we : ram_mem_we}, {31'd0, r_we});
      check("rnd_addr", hit ? dma_mmio_addr : ram_mem_addr, r_addr);
      if (!r_req)          exp_rdata = 32'd0;
      else if (hit)        exp_rdata = 32'hD00D_0000 + ((r_addr - DMA_BASE) >> 2);
      else                 exp_rdata = ram_store[r_addr[9:2]];
      check("rnd_rdata", cpu_mem_rdata, exp_rdata);
    end

    @(negedge clk);
    cpu_mem_req = 1'b0;
    #2;
    check("end_idle_ready", {31'd0, cpu_mem_ready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
